// File: rtl/pwm_capture_pkg.sv
// Shared types and defaults for the PWM period/high-time capture block.
// Optional input synchronizer is enabled by defining PWM_CAPTURE_SYNC_EN.
package pwm_capture_pkg;

   localparam int M_DEFAULT = 10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2
   } state_t;

endpackage

// File: rtl/pwm_edge_detect.sv
// Samples pwm_in (optionally through two flops) and produces rise/fall strobes.
// Two-flop synchronizer is present only when PWM_CAPTURE_SYNC_EN is defined.
module pwm_edge_detect
   import pwm_capture_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic pwm_in,
   output logic rise,
   output logic fall
);

   logic s;
   logic s_d;

`ifdef PWM_CAPTURE_SYNC_EN
   localparam int PW = 3;
   logic [1:0] sync_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= 2'b00;
      end else begin
         sync_q <= {sync_q[0], pwm_in};
      end
   end

   assign s = sync_q[1];
`else
   localparam int PW = 1;
   assign s = pwm_in;
`endif

   // Edges are masked until s_d holds a real sample, so a pin that is
   // already high when reset releases cannot fake a rise.
   logic [PW-1:0] prime;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s_d   <= 1'b0;
         prime <= '0;
      end else begin
         s_d   <= s;
         prime <= (prime << 1) | PW'(1);
      end
   end

   assign rise = prime[PW-1] &  s & ~s_d;
   assign fall = prime[PW-1] & ~s &  s_d;

endmodule

// File: rtl/pwm_capture.sv
// PWM decoder: measures period and high time between qualifying rising edges.
// Define PWM_CAPTURE_SYNC_EN to insert a two-flop synchronizer on pwm_in.
module pwm_capture
   import pwm_capture_pkg::*;
#(
   parameter int M = M_DEFAULT
)
(
   input  logic         clk,
   input  logic         rst,
   input  logic         pwm_in,
   output logic [M-1:0] period,
   output logic [M-1:0] high_time,
   output logic         valid,
   output logic         timeout
);

   localparam logic [M-1:0] CNT_MAX = {M{1'b1}};

   logic         rise;
   logic         fall;
   logic         sat;
   state_t       state;
   logic [M-1:0] cnt;
   logic [M-1:0] hcap;

   pwm_edge_detect u_edge (
      .clk    (clk),
      .rst    (rst),
      .pwm_in (pwm_in),
      .rise   (rise),
      .fall   (fall)
   );

   assign sat = (cnt == CNT_MAX);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (rise) begin
         cnt <= '0;
      end else if (!sat) begin
         cnt <= cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         hcap      <= '0;
         period    <= '0;
         high_time <= '0;
         valid     <= 1'b0;
         timeout   <= 1'b0;
      end else begin
         valid <= 1'b0;
         unique case (state)
            IDLE: begin
               if (rise) begin
                  state <= HIGH;
               end
            end
            HIGH: begin
               if (fall) begin
                  hcap  <= cnt + 1'b1;
                  state <= LOW;
               end else if (sat && !rise) begin
                  timeout <= 1'b1;
                  state   <= IDLE;
               end
            end
            LOW: begin
               if (rise) begin
                  period    <= cnt + 1'b1;
                  high_time <= hcap;
                  valid     <= 1'b1;
                  timeout   <= 1'b0;
                  state     <= HIGH;
               end else if (sat && !fall) begin
                  timeout <= 1'b1;
                  state   <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: waveform table plus timeout/reset/latency cases.
// Builds with or without PWM_CAPTURE_SYNC_EN; expected latency follows the macro.
module tb_pwm_capture;

   localparam int M = 10;

`ifdef PWM_CAPTURE_SYNC_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 1;
`endif

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         pwm_in = 1'b0;
   logic [M-1:0] period;
   logic [M-1:0] high_time;
   logic         valid;
   logic         timeout;

   int total = 0;
   int bad = 0;

   typedef struct {
      logic [M-1:0] p;
      logic [M-1:0] h;
      logic         t;
   } samp_t;

   typedef struct {
      int           hi;
      int           lo;
      logic [M-1:0] ep;
      logic [M-1:0] eh;
   } vec_t;

   samp_t q[$];
   vec_t  vecs[6];
   logic  prev_v = 1'b0;

   pwm_capture #(.M(M)) dut (
      .clk       (clk),
      .rst       (rst),
      .pwm_in    (pwm_in),
      .period    (period),
      .high_time (high_time),
      .valid     (valid),
      .timeout   (timeout)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (valid) begin
         q.push_back('{period, high_time, timeout});
         total++;
         if (prev_v) begin
            bad++;
            $display("FAIL valid_width: valid high %0d cycles in a row, need 1", 2);
         end
      end
      prev_v <= valid;
   end

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic drive(input logic v, input int n);
      repeat (n) begin
         pwm_in = v;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      pwm_in = 1'b0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_period", int'(period), 0);
      check("rst_high", int'(high_time), 0);
      check("rst_valid", int'(valid), 0);
      check("rst_timeout", int'(timeout), 0);
      rst = 1'b0;
      drive(1'b0, 4);
      q.delete();
   endtask

   initial begin
      int k;
      logic got;

      vecs[0] = '{3, 7, 10'd10, 10'd3};
      vecs[1] = '{1, 1, 10'd2, 10'd1};
      vecs[2] = '{5, 5, 10'd10, 10'd5};
      vecs[3] = '{4, 6, 10'd10, 10'd4};
      vecs[4] = '{2, 9, 10'd11, 10'd2};
      vecs[5] = '{1, 20, 10'd21, 10'd1};

      @(posedge clk);
      #1;

      for (int v = 0; v < 6; v++) begin
         do_reset();
         for (int r = 0; r < 4; r++) begin
            drive(1'b1, vecs[v].hi);
            drive(1'b0, vecs[v].lo);
         end
         drive(1'b0, 4);
         check($sformatf("v%0d_count", v), q.size(), 3);
         for (int i = 0; i < q.size() && i < 3; i++) begin
            check($sformatf("v%0d_period%0d", v, i), int'(q[i].p), int'(vecs[v].ep));
            check($sformatf("v%0d_high%0d", v, i), int'(q[i].h), int'(vecs[v].eh));
         end
      end

      // Duty 0: counter runs out after the last rise.
      do_reset();
      drive(1'b1, 3);
      drive(1'b0, 7);
      drive(1'b1, 3);
      pwm_in = 1'b0;
      k = 0;
      got = 1'b0;
      while (!got && k < 1200) begin
         @(posedge clk);
         k++;
         @(negedge clk);
         got = timeout;
      end
      @(posedge clk);
      #1;
      check("to_low_cycles", k, LAT + 1021);
      drive(1'b0, 50);
      check("to_low_valids", q.size(), 1);
      check("to_low_timeout", int'(timeout), 1);

      // Duty 100: arms from IDLE, saturates again, never emits valid.
      drive(1'b1, 1100);
      check("to_high_valids", q.size(), 1);
      check("to_high_timeout", int'(timeout), 1);

      // Recovery with 5/5.
      drive(1'b0, 5);
      drive(1'b1, 5);
      drive(1'b0, 5);
      check("rec_no_valid_yet", q.size(), 1);
      drive(1'b1, 5);
      drive(1'b0, 5);
      check("rec_valids", q.size(), 2);
      if (q.size() >= 2) begin
         check("rec_period", int'(q[1].p), 10);
         check("rec_high", int'(q[1].h), 5);
         check("rec_to_at_valid", int'(q[1].t), 0);
      end
      check("rec_timeout", int'(timeout), 0);

      // Reset pulsed in the middle of a high phase.
      do_reset();
      drive(1'b1, 4);
      drive(1'b0, 6);
      drive(1'b1, 1);
      rst = 1'b1;
      drive(1'b1, 2);
      check("mid_period", int'(period), 0);
      check("mid_high", int'(high_time), 0);
      check("mid_valid", int'(valid), 0);
      check("mid_timeout", int'(timeout), 0);
      rst = 1'b0;
      q.delete();
      drive(1'b1, 1);
      drive(1'b0, 6);
      for (int r = 0; r < 3; r++) begin
         drive(1'b1, 4);
         drive(1'b0, 6);
      end
      drive(1'b0, 4);
      check("mid_count", q.size(), 2);
      for (int i = 0; i < q.size() && i < 2; i++) begin
         check($sformatf("mid_period%0d", i), int'(q[i].p), 10);
         check($sformatf("mid_high%0d", i), int'(q[i].h), 4);
      end

      // Pin rise to valid latency.
      do_reset();
      drive(1'b1, 2);
      drive(1'b0, 2);
      pwm_in = 1'b1;
      k = 0;
      got = 1'b0;
      while (!got && k < 10) begin
         @(posedge clk);
         k++;
         @(negedge clk);
         got = valid;
      end
      check("latency", k, LAT);
      @(posedge clk);
      #1;
      drive(1'b0, 4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
